// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   state_e        : fetch FSM states
//   *_MSB / *_LSB  : MIPS R-format field bit positions inside a 32-bit word
package instr_fetch_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LAST  = 2'd1,
        VALID = 2'd2
    } state_e;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_MSB = 10;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNC_MSB  = 5;
    localparam int unsigned FUNC_LSB  = 0;

endpackage

// File: rtl/instr_field_split.sv
// Purely combinational split of a 32-bit word into MIPS R-format fields.
//   instr_i  : full instruction word
//   op_o     : instr[31:26]     rs_o    : instr[25:21]
//   rt_o     : instr[20:16]     rd_o    : instr[15:11]
//   shamt_o  : instr[10:6]      func_o  : instr[5:0]
module instr_field_split
    import instr_fetch_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output logic [5:0]         op_o,
    output logic [4:0]         rs_o,
    output logic [4:0]         rt_o,
    output logic [4:0]         rd_o,
    output logic [4:0]         shamt_o,
    output logic [5:0]         func_o
);

    assign op_o    = instr_i[OP_MSB:OP_LSB];
    assign rs_o    = instr_i[RS_MSB:RS_LSB];
    assign rt_o    = instr_i[RT_MSB:RT_LSB];
    assign rd_o    = instr_i[RD_MSB:RD_LSB];
    assign shamt_o = instr_i[SHAMT_MSB:SHAMT_LSB];
    assign func_o  = instr_i[FUNC_MSB:FUNC_LSB];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads four bytes per instruction
// from a byte-wide memory (one-cycle read latency), assembles them big-endian
// and presents the word plus decoded fields to decode via valid/ready.
//   clk, reset          : clock, synchronous active-high reset
//   redirect_valid/_pc  : one-cycle PC load (branch/jump), low 2 bits ignored
//   mem_addr/mem_rdata  : byte address out, byte data back one cycle later
//   out_valid/out_ready : handshake towards decode
//   op..func, instr, pc : presented instruction, its fields and byte address
//   fetch_count         : number of accepted instructions (wraps)
module instr_fetch_ctrl
    import instr_fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 32,
    parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         mem_addr,
    input  logic [7:0]          mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [5:0]          op,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [4:0]          shamt,
    output logic [5:0]          func,
    output logic [INSTR_W-1:0]  instr,
    output logic [31:0]         pc,
    output logic [15:0]         fetch_count
);

    // Keeps bits [AW-1:2]: word-aligns and reduces modulo MEM_BYTES in one step.
    localparam logic [31:0] ALIGN_MASK = 32'(MEM_BYTES - 4);

    state_e               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [AW-1:0]        pc_next_q, pc_next_d;
    logic [AW-1:0]        pc_q, pc_d;
    logic [23:0]          asm_q, asm_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [15:0]          fetch_count_q, fetch_count_d;
    logic [AW-1:0]        redirect_target;

    assign redirect_target = AW'(redirect_pc & ALIGN_MASK);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            cnt_q         <= 2'd0;
            pc_next_q     <= '0;
            pc_q          <= '0;
            asm_q         <= '0;
            instr_q       <= '0;
            fetch_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_next_q     <= pc_next_d;
            pc_q          <= pc_d;
            asm_q         <= asm_d;
            instr_q       <= instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_next_d     = pc_next_q;
        pc_d          = pc_q;
        asm_d         = asm_q;
        instr_d       = instr_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            FETCH: begin
                cnt_d = cnt_q + 2'd1;
                // Data arriving now belongs to the address issued last cycle.
                case (cnt_q)
                    2'd1:    asm_d[23:16] = mem_rdata;
                    2'd2:    asm_d[15:8]  = mem_rdata;
                    2'd3:    asm_d[7:0]   = mem_rdata;
                    default: ;
                endcase
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    state_d = LAST;
                end
            end
            LAST: begin
                instr_d = {asm_q, mem_rdata};
                pc_d    = pc_next_q;
                state_d = VALID;
            end
            VALID: begin
                if (out_ready) begin
                    fetch_count_d = fetch_count_q + 16'd1;
                    pc_next_d     = pc_next_q + AW'(4);
                    state_d       = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // Redirect overrides the transition; a completed handshake still counts.
        if (redirect_valid) begin
            pc_next_d = redirect_target;
            cnt_d     = 2'd0;
            state_d   = FETCH;
            instr_d   = instr_q;
            pc_d      = pc_q;
        end
    end

    assign mem_addr    = 32'(pc_next_q + AW'(cnt_q));
    assign out_valid   = (state_q == VALID);
    assign instr       = instr_q;
    assign pc          = 32'(pc_q);
    assign fetch_count = fetch_count_q;

    instr_field_split u_split (
        .instr_i (instr_q),
        .op_o    (op),
        .rs_o    (rs),
        .rt_o    (rt),
        .rd_o    (rd),
        .shamt_o (shamt),
        .func_o  (func)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed plus randomized bench for instr_fetch_ctrl with a byte-memory model.
module tb_instr_fetch_ctrl;

    localparam int unsigned MEM_BYTES = 32;
    localparam int unsigned AW        = $clog2(MEM_BYTES);

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] instr, pc;
    logic [15:0] fetch_count;

    logic [7:0]  mem [MEM_BYTES];
    int          n_checks = 0;
    int          n_pass   = 0;

    instr_fetch_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .op             (op),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .func           (func),
        .instr          (instr),
        .pc             (pc),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Byte memory with one-cycle read latency
    always @(posedge clk) mem_rdata <= mem[AW'(mem_addr % MEM_BYTES)];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] word_at(input int unsigned a);
        return (32'(mem[a % MEM_BYTES]) << 24) |
               (32'(mem[(a + 1) % MEM_BYTES]) << 16) |
               (32'(mem[(a + 2) % MEM_BYTES]) << 8) |
                32'(mem[(a + 3) % MEM_BYTES]);
    endfunction

    task automatic check_presented(input string tag, input int unsigned a, input int unsigned cnt);
        logic [31:0] w;
        w = word_at(a);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".instr"}, instr, w);
        check({tag, ".op"},    32'(op),    w >> 26);
        check({tag, ".rs"},    32'(rs),    (w >> 21) & 32'd31);
        check({tag, ".rt"},    32'(rt),    (w >> 16) & 32'd31);
        check({tag, ".rd"},    32'(rd),    (w >> 11) & 32'd31);
        check({tag, ".shamt"}, 32'(shamt), (w >> 6) & 32'd31);
        check({tag, ".func"},  32'(func),  w & 32'd63);
        check({tag, ".pc"},    pc, a);
        check({tag, ".count"}, 32'(fetch_count), cnt & 32'hFFFF);
    endtask

    // Counts clock edges until out_valid, bounded.
    task automatic wait_valid(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    int unsigned m_pc;
    int unsigned m_age;
    int unsigned m_cnt;
    logic        m_valid;

    initial begin
        for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'($urandom);
        mem[0] = 8'h01; mem[1] = 8'h2A; mem[2] = 8'h40; mem[3] = 8'h20;

        // Reset, with a redirect held to show reset priority
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h14; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.instr", instr, 32'd0);
        check("rst.pc", pc, 32'd0);
        check("rst.count", 32'(fetch_count), 32'd0);
        check("rst.addr", mem_addr, 32'd0);
        reset = 1'b0; redirect_valid = 1'b0;

        // First fetch latency and address sequence
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) @(negedge clk);
            check("lat.valid", 32'(out_valid), (i == 5) ? 32'd1 : 32'd0);
            if (i < 4) check("lat.addr", mem_addr, 32'(i));
        end
        check("first.instr", instr, 32'h012A4020);
        check("first.op", 32'(op), 32'd0);
        check("first.rs", 32'(rs), 32'd9);
        check("first.rt", 32'(rt), 32'd10);
        check("first.rd", 32'(rd), 32'd8);
        check("first.shamt", 32'(shamt), 32'd0);
        check("first.func", 32'(func), 32'h20);
        check("first.pc", pc, 32'd0);
        @(negedge clk);
        check("first.count", 32'(fetch_count), 32'd1);
        check("first.drop", 32'(out_valid), 32'd0);
        check("first.next", mem_addr, 32'd4);

        // Backpressure
        out_ready = 1'b0;
        wait_valid("bp.lat", 5);
        check_presented("bp", 4, 1);
        repeat (10) begin
            @(negedge clk);
            check("bp.valid", 32'(out_valid), 32'd1);
            check("bp.instr", instr, word_at(4));
            check("bp.pc", pc, 32'd4);
            check("bp.addr", mem_addr, 32'd4);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.count", 32'(fetch_count), 32'd2);
        check("bp.next", mem_addr, 32'd8);

        // Redirect to 0x13 during FETCH cnt=2
        repeat (2) @(negedge clk);
        check("rd.cnt2", mem_addr, 32'hA);
        redirect_valid = 1'b1; redirect_pc = 32'h13;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("rd.addr", mem_addr, 32'h10);
        check("rd.count", 32'(fetch_count), 32'd2);
        wait_valid("rd.lat", 5);
        check_presented("rd", 32'h10, 2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rd.acc", 32'(fetch_count), 32'd3);

        // Redirect with out-of-range upper bits and misalignment: target 8
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FF0A;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("rd8.addr", mem_addr, 32'd8);
        wait_valid("rd8.lat", 5);
        check_presented("rd8", 8, 3);

        // Redirect coincident with an accepting handshake
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1C;
        @(negedge clk);
        out_ready = 1'b0; redirect_valid = 1'b0;
        check("co.count", 32'(fetch_count), 32'd4);
        check("co.addr", mem_addr, 32'h1C);
        check("co.valid", 32'(out_valid), 32'd0);
        wait_valid("co.lat", 5);
        check_presented("co", 32'h1C, 4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("wrap.addr", mem_addr, 32'd0);
        wait_valid("wrap.lat", 5);
        check_presented("wrap", 0, 5);

        // fetch_count wrap
        force dut.fetch_count_q = 16'hFFFF;
        #1;
        release dut.fetch_count_q;
        check("fc.pre", 32'(fetch_count), 32'hFFFF);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("fc.wrap", 32'(fetch_count), 32'd0);
        check("fc.addr", mem_addr, 32'd4);

        // Reset asserted in LAST
        repeat (4) @(negedge clk);
        check("rl.notvalid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rl.valid", 32'(out_valid), 32'd0);
        check("rl.instr", instr, 32'd0);
        check("rl.pc", pc, 32'd0);
        check("rl.count", 32'(fetch_count), 32'd0);
        check("rl.addr", mem_addr, 32'd0);
        reset = 1'b0;
        wait_valid("rl.lat", 5);
        check_presented("rl", 0, 0);

        // Randomized traffic against a cycle-age reference model
        reset = 1'b1;
        for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'($urandom);
        @(negedge clk);
        reset = 1'b0;
        m_pc = 0; m_age = 0; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            m_valid = (m_age >= 5);
            check("rnd.valid", 32'(out_valid), 32'(m_valid));
            if (m_age < 4) check("rnd.addr", mem_addr, m_pc + m_age);
            if (m_valid) check_presented("rnd", m_pc, m_cnt);

            out_ready      = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;

            if (m_valid && out_ready) begin
                m_cnt = (m_cnt + 1) & 32'hFFFF;
                m_pc  = (m_pc + 4) % MEM_BYTES;
                m_age = 0;
            end else begin
                m_age++;
            end
            if (redirect_valid) begin
                m_pc  = (redirect_pc % MEM_BYTES) & ~32'd3;
                m_age = 0;
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
